// File: rtl/pd_inst_buf_pkg.sv
// Purpose : MIPS ISA field constants and the buffer entry layout shared by the
//           predecode logic and the pd instruction buffer.
// Contents: opcode / funct / REGIMM rt constants, pd_entry_t.
package pd_inst_buf_pkg;

  // Primary opcodes (inst[31:26])
  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_REGIMM  = 6'b000001;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_BLEZ    = 6'b000110;
  localparam logic [5:0] OP_BGTZ    = 6'b000111;

  // SPECIAL funct codes (inst[5:0])
  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_JALR    = 6'b001001;

  // REGIMM rt codes (inst[20:16])
  localparam logic [4:0] RT_BLTZ    = 5'b00000;
  localparam logic [4:0] RT_BGEZ    = 5'b00001;
  localparam logic [4:0] RT_BLTZAL  = 5'b10000;
  localparam logic [4:0] RT_BGEZAL  = 5'b10001;

  // One queued instruction; predecode flags are captured at write time.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        jump;
    logic        bd;
  } pd_entry_t;

endpackage

// File: rtl/pd_jump_detect.sv
// Purpose : flags branch/jump encodings (control-transfer with a delay slot).
// Latency : purely combinational, no state.
// Ports   : inst_i[31:0] instruction word -> jump_o high for branch/jump.
module pd_jump_detect
  import pd_inst_buf_pkg::*;
(
  input  logic [31:0] inst_i,
  output logic        jump_o
);

  logic [5:0] op;
  logic [4:0] rt;
  logic [5:0] funct;

  assign op    = inst_i[31:26];
  assign rt    = inst_i[20:16];
  assign funct = inst_i[5:0];

  always_comb begin
    jump_o = 1'b0;
    unique case (op)
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_J, OP_JAL: jump_o = 1'b1;
      OP_REGIMM:
        jump_o = (rt == RT_BLTZ) || (rt == RT_BGEZ) ||
                 (rt == RT_BLTZAL) || (rt == RT_BGEZAL);
      OP_SPECIAL:
        jump_o = (funct == FN_JR) || (funct == FN_JALR);
      default: jump_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/pd_inst_buf.sv
// Purpose : pd-stage instruction FIFO with write-time predecode (jump / delay slot).
// Latency : push at cycle N is visible at the head in N+1; a jump waits for its delay slot.
// Backpr. : if_ready drops only when full (no read bypass); stall holds the head entry.
// Ports   : clk/resetn; refresh flush; IF side if_valid/if_pc/if_inst/if_ready;
//           ID side stall, pd_valid/pd_pc/pd_inst/pd_bd/pd_jump (zeroed when not valid).
module pd_inst_buf
  import pd_inst_buf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        refresh,
  input  logic        if_valid,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_inst,
  output logic        if_ready,
  input  logic        stall,
  output logic        pd_valid,
  output logic [31:0] pd_pc,
  output logic [31:0] pd_inst,
  output logic        pd_bd,
  output logic        pd_jump
);

  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);

  pd_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             last_jump_q, last_jump_d;

  logic      wr_jump;
  logic      push, pop;
  pd_entry_t head;

  pd_jump_detect u_jump_detect (
    .inst_i (if_inst),
    .jump_o (wr_jump)
  );

  // Full is judged from count alone, so a same-cycle pop never frees a slot.
  assign if_ready = (count_q < CNT_FULL);
  assign push     = if_valid & if_ready;

  assign head     = mem_q[rd_ptr_q];
  // A jump is held back until its delay slot sits behind it, so ID always
  // receives the pair on consecutive pops.
  assign pd_valid = (count_q != '0) & ~(head.jump & (count_q < CNT_TWO));
  assign pop      = pd_valid & ~stall;

  assign pd_pc    = pd_valid ? head.pc   : 32'h0;
  assign pd_inst  = pd_valid ? head.inst : 32'h0;
  assign pd_bd    = pd_valid ? head.bd   : 1'b0;
  assign pd_jump  = pd_valid ? head.jump : 1'b0;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    last_jump_d = last_jump_q;
    if (refresh) begin
      // Flush wins over any same-cycle push/pop.
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      last_jump_d = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d    = wr_ptr_q + PTR_W'(1);
        last_jump_d = wr_jump;
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      last_jump_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      last_jump_q <= last_jump_d;
      // The delay-slot flag is the previous push's jump flag.
      if (push && !refresh) begin
        mem_q[wr_ptr_q] <= '{pc: if_pc, inst: if_inst, jump: wr_jump, bd: last_jump_q};
      end
    end
  end

endmodule
